// File: rtl/targ_tx_feeder_if.sv
// Launch handshake between the byte feeder and the target-UART transmitter.
// The feeder drives the strobe and data; the transmitter answers with busy.
interface targ_tx_feeder_if;
  logic       TxD_start;
  logic [7:0] TxD_data;
  logic       TxD_busy;

  modport master (output TxD_start, output TxD_data, input TxD_busy);
  modport slave  (input TxD_start, input TxD_data, output TxD_busy);
endinterface

// File: rtl/targ_tx_feeder.sv
// Byte FIFO plus launch sequencer feeding the target-UART transmitter, with an
// optional idle gap between characters and occupancy/overflow status.
module targ_tx_feeder #(
  parameter int DEPTH_LOG2 = 7,
  parameter int GAP_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 wr_en,
  input  logic [7:0]           wr_data,
  input  logic                 flush,
  input  logic                 clear_overflow,
  input  logic [GAP_WIDTH-1:0] gap_cycles,
  targ_tx_feeder_if.master     tx,
  output logic [DEPTH_LOG2:0]  fifo_count,
  output logic                 fifo_empty,
  output logic                 fifo_full,
  output logic                 overflow,
  output logic                 idle
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]  FULL_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [GAP_WIDTH-1:0] GAP_ONE  = 1;

  typedef enum logic [2:0] {
    S_IDLE, S_LAUNCH, S_WAIT_ACK, S_WAIT_DONE, S_GAP
  } state_t;

  state_t                state_q, state_d;
  logic [GAP_WIDTH-1:0]  gap_cnt_q, gap_cnt_d;
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic                  overflow_q, overflow_d;
  logic                  tx_start_q, tx_start_d;
  logic [7:0]            tx_data_q, tx_data_d;
  logic [7:0]            mem [DEPTH];

  logic empty, full, push, pop, drop;

  assign empty = (count_q == '0);
  assign full  = (count_q == FULL_CNT);
  // Fullness is judged before any same-cycle pop, so a write at full is always dropped.
  assign push  = wr_en && !full && !flush;
  assign drop  = wr_en && full;
  assign pop   = (state_q == S_IDLE) && !empty && !tx.TxD_busy && !flush;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q] <= wr_data;
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_comb begin
    overflow_d = overflow_q;
    if (drop) begin
      overflow_d = 1'b1;
    end else if (clear_overflow) begin
      overflow_d = 1'b0;
    end
  end

  // FSM: state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      gap_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      gap_cnt_q <= gap_cnt_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d   = state_q;
    gap_cnt_d = gap_cnt_q;
    case (state_q)
      S_IDLE:     if (pop) state_d = S_LAUNCH;
      S_LAUNCH:   state_d = S_WAIT_ACK;
      S_WAIT_ACK: if (tx.TxD_busy) state_d = S_WAIT_DONE;
      S_WAIT_DONE: begin
        if (!tx.TxD_busy) begin
          if (gap_cycles != '0) begin
            state_d   = S_GAP;
            gap_cnt_d = gap_cycles;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_GAP: begin
        if (gap_cnt_q <= GAP_ONE) begin
          state_d = S_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q - 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM: outputs, registered so the strobe lines up with the LAUNCH state
  always_comb begin
    tx_start_d = (state_d == S_LAUNCH);
    tx_data_d  = pop ? mem[rd_ptr_q] : tx_data_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      tx_start_q <= 1'b0;
      tx_data_q  <= 8'h00;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
    end
  end

  assign tx.TxD_start = tx_start_q;
  assign tx.TxD_data  = tx_data_q;
  assign fifo_count   = count_q;
  assign fifo_empty   = empty;
  assign fifo_full    = full;
  assign overflow     = overflow_q;
  assign idle         = (state_q == S_IDLE) && empty && !tx.TxD_busy;

endmodule

// File: tb/tb_targ_tx_feeder.sv
// Scoreboard bench for targ_tx_feeder: bytes are queued as they are written and
// popped by a small transmitter model each time the feeder strobes TxD_start.
module tb_targ_tx_feeder;
  localparam int DL2      = 7;
  localparam int GW       = 16;
  localparam int CHAR_LEN = 8;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          wr_en = 1'b0;
  logic [7:0]    wr_data = 8'h00;
  logic          flush = 1'b0;
  logic          clear_overflow = 1'b0;
  logic [GW-1:0] gap_cycles = '0;
  logic [DL2:0]  fifo_count;
  logic          fifo_empty, fifo_full, overflow, idle;

  targ_tx_feeder_if txif();

  targ_tx_feeder #(.DEPTH_LOG2(DL2), .GAP_WIDTH(GW)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .wr_en          (wr_en),
    .wr_data        (wr_data),
    .flush          (flush),
    .clear_overflow (clear_overflow),
    .gap_cycles     (gap_cycles),
    .tx             (txif.master),
    .fifo_count     (fifo_count),
    .fifo_empty     (fifo_empty),
    .fifo_full      (fifo_full),
    .overflow       (overflow),
    .idle           (idle)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          checks = 0;
  int          errors = 0;
  logic [7:0]  exp_q[$];
  int          n_starts = 0;
  int unsigned start_cyc = 0;
  int unsigned fall_cyc = 0;
  int unsigned last_delta = 0;
  logic        hold_busy = 1'b0;
  int          busy_left = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Transmitter model: busy rises right after a strobe and falls CHAR_LEN cycles later.
  // Delays are measured up to the edge on which the transmitter samples the strobe.
  initial begin
    txif.TxD_busy = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (txif.TxD_start) begin
        chk("start_vs_busy", {31'd0, txif.TxD_busy}, 0);
        chk("sb_pending", {31'd0, exp_q.size() != 0}, 1);
        if (exp_q.size() != 0) chk("tx_data", {24'd0, txif.TxD_data}, {24'd0, exp_q.pop_front()});
        $display("tx byte 0x%02h at cycle %0d", txif.TxD_data, cyc);
        n_starts++;
        start_cyc  = cyc;
        last_delta = cyc - fall_cyc + 1;
        busy_left  = CHAR_LEN;
        txif.TxD_busy = 1'b1;
      end else if (busy_left > 0) begin
        busy_left--;
        if (busy_left == 0) begin
          txif.TxD_busy = hold_busy;
          fall_cyc = cyc;
        end
      end else begin
        txif.TxD_busy = hold_busy;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_byte(input logic [7:0] b, input bit accept);
    wr_data = b;
    wr_en   = 1'b1;
    if (accept) exp_q.push_back(b);
    tick();
    wr_en = 1'b0;
  endtask

  task automatic wait_starts(input int target, input int budget, input string tag);
    int n = 0;
    while (n_starts < target && n < budget) begin
      tick();
      n++;
    end
    chk(tag, {31'd0, n_starts >= target}, 1);
  endtask

  task automatic wait_drain(input int budget, input string tag);
    int n = 0;
    bit done = 1'b0;
    while (!done && n < budget) begin
      tick();
      n++;
      done = idle && (exp_q.size() == 0) && (busy_left == 0);
    end
    chk(tag, {31'd0, done}, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_start"}, {31'd0, txif.TxD_start}, 0);
    chk({tag, "_data"},  {24'd0, txif.TxD_data}, 0);
    chk({tag, "_count"}, {24'd0, fifo_count}, 0);
    chk({tag, "_empty"}, {31'd0, fifo_empty}, 1);
    chk({tag, "_full"},  {31'd0, fifo_full}, 0);
    chk({tag, "_ovf"},   {31'd0, overflow}, 0);
    chk({tag, "_idle"},  {31'd0, idle}, {31'd0, !txif.TxD_busy});
  endtask

  initial begin
    int unsigned wr_cyc;
    int base;
    bit saw_full;

    // Reset values
    repeat (3) tick();
    check_reset_outputs("rst");
    reset_n = 1'b1;
    tick();

    // Single byte, gap 0
    push_byte(8'hA5, 1'b1);
    wr_cyc = cyc;
    chk("single_cnt1", {24'd0, fifo_count}, 1);
    tick();
    chk("single_cnt0", {24'd0, fifo_count}, 0);
    chk("single_strobe", {31'd0, txif.TxD_start}, 1);
    chk("single_data", {24'd0, txif.TxD_data}, 8'hA5);
    wait_starts(1, 20, "single_wait");
    chk("single_latency", start_cyc - wr_cyc + 1, 2);
    wait_drain(100, "single_drain");
    chk("single_idle", {31'd0, idle}, 1);

    // Back-to-back with no gap
    base = n_starts;
    push_byte(8'h11, 1'b1);
    push_byte(8'h22, 1'b1);
    wait_starts(base + 2, 100, "gap0_wait");
    chk("gap0_delay", last_delta, 3);
    wait_drain(100, "gap0_drain");

    // Programmable gap of 10
    gap_cycles = 16'd10;
    base = n_starts;
    push_byte(8'h33, 1'b1);
    push_byte(8'h44, 1'b1);
    wait_starts(base + 2, 100, "gap10_wait");
    chk("gap10_delay", last_delta, 13);
    wait_drain(100, "gap10_drain");
    gap_cycles = '0;

    // Burst of 128 bytes streaming out in order
    saw_full = 1'b0;
    for (int i = 0; i < 128; i++) begin
      push_byte(i[7:0], 1'b1);
      if (fifo_full) saw_full = 1'b1;
    end
    chk("burst_full", {31'd0, saw_full}, 0);
    wait_drain(5000, "burst_drain");
    chk("burst_ovf", {31'd0, overflow}, 0);

    // Overflow with the transmitter held busy
    hold_busy = 1'b1;
    repeat (2) tick();
    for (int i = 0; i < 128; i++) push_byte(i[7:0] ^ 8'h5A, 1'b1);
    push_byte(8'hEE, 1'b0);
    chk("ovf_count", {24'd0, fifo_count}, 128);
    chk("ovf_full", {31'd0, fifo_full}, 1);
    chk("ovf_empty", {31'd0, fifo_empty}, 0);
    chk("ovf_flag", {31'd0, overflow}, 1);
    wr_data = 8'hEF;
    wr_en = 1'b1;
    clear_overflow = 1'b1;
    tick();
    wr_en = 1'b0;
    chk("ovf_clr_vs_drop", {31'd0, overflow}, 1);
    tick();
    clear_overflow = 1'b0;
    chk("ovf_cleared", {31'd0, overflow}, 0);
    chk("ovf_count2", {24'd0, fifo_count}, 128);
    hold_busy = 1'b0;
    wait_drain(5000, "ovf_drain");

    // Flush during the first character
    base = n_starts;
    for (int i = 0; i < 5; i++) push_byte(8'hC0 + i[7:0], 1'b1);
    wait_starts(base + 1, 50, "flush_wait");
    flush = 1'b1;
    exp_q.delete();
    tick();
    flush = 1'b0;
    chk("flush_count", {24'd0, fifo_count}, 0);
    chk("flush_empty", {31'd0, fifo_empty}, 1);
    repeat (40) tick();
    chk("flush_nostart", n_starts, base + 1);
    wait_drain(100, "flush_drain");

    // Reset in the middle of a character
    base = n_starts;
    for (int i = 0; i < 3; i++) push_byte(8'h90 + i[7:0], 1'b1);
    wait_starts(base + 1, 50, "mrst_wait");
    repeat (2) tick();
    reset_n = 1'b0;
    exp_q.delete();
    #1;
    check_reset_outputs("mrst");
    tick();
    reset_n = 1'b1;
    push_byte(8'h3C, 1'b1);
    chk("mrst_no_early_start", n_starts, base + 1);
    wait_starts(base + 2, 50, "mrst_restart");
    wait_drain(100, "mrst_drain");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/targ_tx_feeder.md
# targ_tx_feeder

Byte FIFO and launch sequencer that sits directly upstream of the target-UART transmitter. It accepts bytes from the register interface at any rate, buffers them, and presents them one at a time on the transmitter's `TxD_start`/`TxD_data`/`TxD_busy` handshake. An optional programmable idle gap is inserted between characters. Occupancy and overflow status are reported back to the register interface.

## Interface
- `DEPTH_LOG2`, default 7: FIFO depth is 2^DEPTH_LOG2 bytes (128).
- `GAP_WIDTH`, default 16: width of the inter-character gap counter.

- `clk`  in  1  system clock, shared with the transmitter.
- `reset_n`  in  1  asynchronous, active-low reset.
- `wr_en`  in  1  push `wr_data` this cycle.
- `wr_data`  in  8  byte to enqueue.
- `flush`  in  1  synchronous FIFO clear.
- `clear_overflow`  in  1  clears sticky `overflow`.
- `gap_cycles`  in  GAP_WIDTH  idle clocks inserted after each character; 0 means no gap.
- `TxD_busy`  in  1  transmitter busy.
- `TxD_start`  out  1  one-cycle launch strobe to the transmitter.
- `TxD_data`  out  8  byte to the transmitter.
- `fifo_count`  out  DEPTH_LOG2+1  current occupancy, 0..2^DEPTH_LOG2.
- `fifo_empty`  out  1  `fifo_count`==0.
- `fifo_full`  out  1  `fifo_count`==2^DEPTH_LOG2.
- `overflow`  out  1  sticky; a write was dropped.
- `idle`  out  1  FSM in IDLE, FIFO empty and `TxD_busy` low.

## Operation
- FIFO: circular buffer with read/write pointers of DEPTH_LOG2 bits that wrap naturally, plus a registered count. It is first-word-fall-through internally. The pop happens only on the FSM's IDLE→LAUNCH transition.
- Write when full: the byte is dropped and `overflow` is set. This applies even if a pop occurs in the same cycle, because fullness is evaluated before the pop.
- Simultaneous push and pop when not full: both take effect and the count is unchanged.
- `flush`: pointers and count go to 0. Flush wins over a write in the same cycle. It does not abort a byte already popped.
- `clear_overflow` and a dropping write in the same cycle: `overflow` stays 1.
- FSM states:
  - IDLE → LAUNCH when the FIFO is not empty and `TxD_busy`==0. On this transition pop the head into the `TxD_data` register.
  - LAUNCH: `TxD_start`=1 for exactly this cycle. Always → WAIT_ACK.
  - WAIT_ACK → WAIT_DONE when `TxD_busy`==1.
  - WAIT_DONE → GAP when `TxD_busy`==0 and `gap_cycles`!=0, loading the counter with `gap_cycles`. If `gap_cycles`==0, → IDLE instead.
  - GAP: the counter decrements each cycle. → IDLE when the counter reaches 1.
- `TxD_data` holds its value from the pop until the next pop, so it never changes while the transmitter is busy.
- Changes to `gap_cycles` affect only the next gap load.

## Timing
- Reset values: `TxD_start`=0, `TxD_data`=0x00, `fifo_count`=0, `fifo_empty`=1, `fifo_full`=0, `overflow`=0, FSM=IDLE, `idle`=1 (provided `TxD_busy` is low).
- All outputs are registered except `idle`, `fifo_empty` and `fifo_full`, which are decoded from registers.
- Write latency: with `wr_en` sampled at edge N into an empty FIFO with an idle transmitter:
  - `fifo_count`=1 after edge N.
  - Pop at edge N+1.
  - `TxD_start` is high for exactly one cycle between edges N+1 and N+2.
- Back-to-back characters (gap 0): the next `TxD_start` comes 3 clocks after `TxD_busy` falls (WAIT_DONE→IDLE→LAUNCH→strobe).
- Gap g>0: the next `TxD_start` comes g+3 clocks after `TxD_busy` falls.
- Reset mid-character: the FSM returns to IDLE and the FIFO is emptied. A transmitter still busy is never re-strobed until `TxD_busy` falls.
- `TxD_start` is never asserted while `TxD_busy`=1.

## Test plan
- Single byte: write 0xA5 into an empty FIFO with gap 0.
  - `TxD_start` pulses once, 2 clocks after the write.
  - `TxD_data`=0xA5 during the pulse.
  - `fifo_count` goes 1→0.
  - `idle` returns to 1 after busy falls.
- Burst ordering: write 0x00..0x7F back-to-back (128 bytes).
  - `fifo_full` goes high only if no pop has happened yet.
  - The transmitter model receives 0x00..0x7F in order, with no drops and `overflow`=0.
- Overflow: hold `TxD_busy`=1 and write 129 bytes.
  - `fifo_count`=128, `fifo_full`=1, `overflow`=1.
  - The 129th byte is never sent.
  - `clear_overflow` returns `overflow` to 0.
- Gap: set `gap_cycles`=10 and queue 2 bytes.
  - The second `TxD_start` comes exactly 13 clocks after `TxD_busy` falls.
- Flush and reset: queue 5 bytes, then assert `flush` during the first character.
  - The first byte completes, no further `TxD_start` occurs, and `fifo_count`=0.
- Reset mid-character: assert `reset_n`=0 mid-character.
  - All outputs take their reset values.
  - No `TxD_start` occurs until `TxD_busy` is low.
